perceptron_train: RTL
=====================

Name: perceptron_train

Overview:
- Training/update engine for the perceptron branch predictor; the write side of the weight table that the fast-path predict logic reads.
- Accepts one resolved-branch record per handshake.
- Decides whether training is required (mispredict, or |sum| <= THETA); if so, performs a read-modify-write of one weight-table row with saturating ±1 updates, then writes the row back.
- Sits between the branch-resolution stage and the weight table.

Parameters:
- WEIGHT_NUM, 33, weights per row (index 0 = bias, 1..32 = history bits).
- WEIGHT_WIDTH, 8, signed two's-complement weight width.
- WEIGHT_ENTRY_NUM, 64, rows in weight table.
- IDX_WIDTH, 6, log2(WEIGHT_ENTRY_NUM).
- THETA, 75, training threshold (floor(1.93*32+14)), unsigned.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- upd_valid  in  1  resolved-branch record valid.
- upd_ready  out  1  engine can accept a record.
- upd_idx  in  IDX_WIDTH  weight-table row used at prediction.
- upd_taken  in  1  actual outcome (1 = taken).
- upd_pred  in  1  predicted outcome.
- upd_sum  in  WEIGHT_WIDTH  signed perceptron output at prediction.
- upd_hist  in  WEIGHT_NUM-1  global history at prediction; bit i-1 pairs with weight i.
- wt_rd_en  out  1  weight-table read strobe.
- wt_rd_idx  out  IDX_WIDTH  read row.
- wt_rd_data  in  WEIGHT_NUM*WEIGHT_WIDTH  row data; valid the cycle after wt_rd_en; weight i at bits [i*W+W-1 : i*W].
- wt_wr_en  out  1  weight-table write strobe.
- wt_wr_idx  out  IDX_WIDTH  write row.
- wt_wr_data  out  WEIGHT_NUM*WEIGHT_WIDTH  updated row, same packing as wt_rd_data.
- train_cnt  out  16  count of rows written; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - wt_rd_en=0, wt_wr_en=0; wt_rd_idx, wt_wr_idx, wt_wr_data = 0.
  - train_cnt=0; all capture registers 0.
  - upd_ready=1, since it is derived as (state==IDLE).
- Handshake: accept on the rising edge where upd_valid && upd_ready; all upd_* fields are captured into registers then. upd_ready=0 in every state except IDLE.
- Train decision, evaluated on upd_* at acceptance:
  - |sum| is computed in WEIGHT_WIDTH+1 bits, so -128 gives 128.
  - train = (upd_pred != upd_taken) || (|sum| <= THETA).
  - If train=0: remain IDLE, no table access, record dropped; back-to-back accepts are allowed every cycle.
- States, for a record accepted at edge T when train=1:
  - IDLE -> READ at edge T.
  - READ: one cycle, during cycle T+1; wt_rd_en=1, wt_rd_idx=captured idx. Next state CALC.
  - CALC: one cycle, during cycle T+2; latch wt_rd_data and compute the new row into wt_wr_data; next state WRITE. Per weight i:
    - t = +1 if taken, else -1.
    - x0 = +1; xi = +1 if hist[i-1], else -1.
    - w_i' = sat(w_i + t*xi), clamped to [-2^(W-1), 2^(W-1)-1], i.e. [-128, 127].
  - WRITE: one cycle, during cycle T+3; wt_wr_en=1, wt_wr_idx=captured idx, wt_wr_data=registered new row. train_cnt increments at the end of this cycle (wraps 0xFFFF -> 0). Next state IDLE.
  - upd_ready returns to 1 in cycle T+4. Sustained training throughput is one record per 4 cycles.
- Strobes and outputs:
  - wt_rd_en and wt_wr_en are single-cycle pulses and are never high in the same cycle.
  - wt_wr_data and wt_wr_idx hold their last values outside WRITE.
- No bypass of pending writes is needed; only one record is ever in flight.
- Reset mid-operation: the record is abandoned and no write occurs (a WRITE interrupted by reset deasserts wt_wr_en immediately). train_cnt clears.
- upd_valid while busy is ignored; the source must hold the record until ready.

Test Plan:
- Reset, then hold: upd_ready=1, wt_rd_en=wt_wr_en=0, train_cnt=0; assert rst_n=0 mid-WRITE -> wt_wr_en falls asynchronously, state IDLE.
- Correct prediction, sum=+100 (>THETA), three consecutive cycles -> three accepts, no wt_rd_en/wt_wr_en, train_cnt=0.
- Mispredict: idx=5, taken=1, pred=0, sum=-3, hist=0x0000_0001, row of all 0x00 -> wt_rd_en in T+1 (idx 5), wt_wr_en in T+3 (idx 5); w0=+1, w1=+1, w2..w32=0xFF (-1); train_cnt=1; upd_ready=1 at T+4.
- Saturation: taken=1, pred=1, sum=10 (≤THETA), hist=all 1s, row all 0x7F -> written row all 0x7F; repeat with taken=0, pred=0, sum=-10, row all 0x80 -> row all 0x80.
- Boundary |sum|: sum=+75 with a correct prediction -> trains; sum=+76 -> no train; sum=-128 (abs 128) correct -> no train.
- Busy backpressure: second record asserted during READ/CALC/WRITE -> not accepted until T+4; then accepted and written with its own idx. Preset train_cnt to 0xFFFF via 65535 trainings -> next write wraps it to 0.

Source files
------------

// File: rtl/perceptron_train.sv
// Training engine for the perceptron branch predictor: filters resolved branches
// and does a read / saturating update / write-back of one weight-table row.
module perceptron_train #(
    parameter int WEIGHT_NUM       = 33,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int WEIGHT_ENTRY_NUM = 64,
    parameter int IDX_WIDTH        = 6,
    parameter int THETA            = 75
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               upd_valid,
    output logic                               upd_ready,
    input  logic [IDX_WIDTH-1:0]               upd_idx,
    input  logic                               upd_taken,
    input  logic                               upd_pred,
    input  logic [WEIGHT_WIDTH-1:0]            upd_sum,
    input  logic [WEIGHT_NUM-2:0]              upd_hist,
    output logic                               wt_rd_en,
    output logic [IDX_WIDTH-1:0]               wt_rd_idx,
    input  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] wt_rd_data,
    output logic                               wt_wr_en,
    output logic [IDX_WIDTH-1:0]               wt_wr_idx,
    output logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] wt_wr_data,
    output logic [15:0]                        train_cnt
);

    localparam int W   = WEIGHT_WIDTH;
    localparam int ROW = WEIGHT_NUM * WEIGHT_WIDTH;
    localparam logic [W:0]   THETA_V = (W+1)'(THETA);
    localparam logic [W-1:0] W_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] W_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

    state_t                state;
    state_t                next_state;
    logic [IDX_WIDTH-1:0]  cap_idx;
    logic                  cap_taken;
    logic [WEIGHT_NUM-2:0] cap_hist;
    logic                  accept;
    logic                  train;
    logic [W:0]            sum_abs;
    logic [WEIGHT_NUM-1:0] x_vec;
    logic [ROW-1:0]        new_row;

    assign accept = upd_valid && upd_ready;

    // One extra bit so that the most negative sum still has a representable magnitude.
    always_comb begin
        if (upd_sum[W-1]) begin
            sum_abs = -{1'b1, upd_sum};
        end else begin
            sum_abs = {1'b0, upd_sum};
        end
        train = (upd_pred != upd_taken) || (sum_abs <= THETA_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && train) next_state = READ;
            READ:    next_state = CALC;
            CALC:    next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes decode straight from state so reset drops a pending write at once.
    always_comb begin
        upd_ready = (state == IDLE);
        wt_rd_en  = (state == READ);
        wt_wr_en  = (state == WRITE);
    end

    // Prediction and sum are only needed for the train decision at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_idx   <= '0;
            cap_taken <= 1'b0;
            cap_hist  <= '0;
        end else if (accept) begin
            cap_idx   <= upd_idx;
            cap_taken <= upd_taken;
            cap_hist  <= upd_hist;
        end
    end

    assign wt_rd_idx = cap_idx;
    assign x_vec     = {cap_hist, 1'b1};

    // t*x is +1 exactly when the outcome agrees with the input sign.
    always_comb begin
        new_row = '0;
        for (int i = 0; i < WEIGHT_NUM; i++) begin
            if (x_vec[i] == cap_taken) begin
                new_row[i*W +: W] = (wt_rd_data[i*W +: W] == W_MAX) ?
                                    W_MAX : wt_rd_data[i*W +: W] + 1'b1;
            end else begin
                new_row[i*W +: W] = (wt_rd_data[i*W +: W] == W_MIN) ?
                                    W_MIN : wt_rd_data[i*W +: W] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_wr_data <= '0;
            wt_wr_idx  <= '0;
        end else if (state == CALC) begin
            wt_wr_data <= new_row;
            wt_wr_idx  <= cap_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            train_cnt <= '0;
        end else if (state == WRITE) begin
            train_cnt <= train_cnt + 16'd1;
        end
    end

endmodule
